// File: rtl/sd_boot_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sd_boot_sequencer_if
// Purpose  : Bus bundle between the boot sequencer and its three neighbours:
//            the memory controller write/read port (mc_*), the SD file loader
//            handshake (ld_*) and the CPU memory request port (cpu_*).
// Modports : master - the boot sequencer (drives mc_* requests, ld_* acks,
//                     cpu_* responses)
//            slave  - the surrounding system (memory controller, loader, CPU)
// Revision : 1.0 - initial release
// ============================================================================
interface sd_boot_sequencer_if;
  // memory controller port
  logic        mc_init_done;
  logic [7:0]  mc_ctrl_state;
  logic [31:0] mc_rdata;
  logic [31:0] mc_addr;
  logic [31:0] mc_wdata;
  logic        mc_we;
  logic        mc_re;
  // SD loader handshake
  logic [31:0] ld_data;
  logic        ld_we;
  logic        ld_done;
  logic [2:0]  ld_main_init_state;
  logic [7:0]  ld_ctrl_state;
  // CPU memory request port
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_we;
  logic        cpu_re;
  logic [31:0] cpu_rdata;
  logic [7:0]  cpu_ctrl_state;

  modport master (
    input  mc_init_done, mc_ctrl_state, mc_rdata,
    output mc_addr, mc_wdata, mc_we, mc_re,
    input  ld_data, ld_we, ld_done,
    output ld_main_init_state, ld_ctrl_state,
    input  cpu_addr, cpu_wdata, cpu_we, cpu_re,
    output cpu_rdata, cpu_ctrl_state
  );

  modport slave (
    output mc_init_done, mc_ctrl_state, mc_rdata,
    input  mc_addr, mc_wdata, mc_we, mc_re,
    output ld_data, ld_we, ld_done,
    input  ld_main_init_state, ld_ctrl_state,
    output cpu_addr, cpu_wdata, cpu_we, cpu_re,
    input  cpu_rdata, cpu_ctrl_state
  );
endinterface
`default_nettype wire

// File: rtl/sd_boot_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sd_boot_sequencer
// Purpose  : Boot-time controller. Pulls 32-bit words from the SD loader,
//            writes each one to memory at BASE_ADDR+offset, holds the CPU in
//            reset until the full image (BIN_BYTES) is written, then hands the
//            memory port to the CPU. Loader stalls, short images and overlong
//            images end in a sticky error.
// Ports    : clk27mhz     - clock
//            resetn       - synchronous active-low reset
//            bus          - mc_*/ld_*/cpu_* bundle (master side)
//            cpu_rst_n    - CPU reset, released only on successful boot
//            load_done    - sticky: image fully written
//            load_err     - sticky: timeout or size mismatch
//            checksum     - mod-2^32 sum of committed words
//            words_loaded - number of committed words
// Revision : 1.0 - initial release
// ============================================================================
module sd_boot_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] BIN_BYTES = 32'h0010_0000,
  parameter logic [31:0] TIMEOUT   = 32'd54_000_000
) (
  input  logic                clk27mhz,
  input  logic                resetn,
  sd_boot_sequencer_if.master bus,
  output logic                cpu_rst_n,
  output logic                load_done,
  output logic                load_err,
  output logic [31:0]         checksum,
  output logic [29:0]         words_loaded
);

  localparam logic [2:0] S_INIT      = 3'd0;
  localparam logic [2:0] S_LOAD_WAIT = 3'd1;
  localparam logic [2:0] S_MC_REQ    = 3'd2;
  localparam logic [2:0] S_MC_ACK    = 3'd3;
  localparam logic [2:0] S_REL       = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;
  localparam logic [2:0] S_ERROR     = 3'd6;

  logic [2:0]  state;
  logic [2:0]  next_state;
  logic [31:0] offset;
  logic [31:0] wbuf;
  logic [31:0] timer;
  logic [31:0] mc_addr_q;
  logic [31:0] mc_wdata_q;
  logic        mc_we_q;
  logic [2:0]  ld_main_q;
  logic [7:0]  ld_ctrl_q;

  logic        image_full;
  logic        mc_idle;
  logic [31:0] timer_inc;
  logic        timer_hit;
  logic        load_phase;
  logic        in_done;

  assign image_full = (offset == BIN_BYTES);
  assign mc_idle    = (bus.mc_ctrl_state == 8'h00);
  // Saturating increment; the timeout fires on the edge the count reaches TIMEOUT.
  assign timer_inc  = (timer >= TIMEOUT) ? TIMEOUT : timer + 32'd1;
  assign timer_hit  = (timer_inc >= TIMEOUT);
  // The timer keeps running through the memory write so it measures the full
  // gap between loader words, not just the time spent waiting in LOAD_WAIT.
  assign load_phase = (state == S_LOAD_WAIT) || (state == S_MC_REQ) ||
                      (state == S_MC_ACK)    || (state == S_REL);
  assign in_done    = (state == S_DONE);

  always_comb begin
    next_state = state;
    case (state)
      S_INIT:      if (bus.mc_init_done) next_state = S_LOAD_WAIT;
      S_LOAD_WAIT: begin
        // A word presented together with ld_done is taken first; ld_done is
        // looked at again once the handshake returns here.
        if (bus.ld_we)        next_state = image_full ? S_ERROR : S_MC_REQ;
        else if (bus.ld_done) next_state = image_full ? S_DONE  : S_ERROR;
        else if (timer_hit)   next_state = S_ERROR;
      end
      S_MC_REQ:    if (mc_idle)     next_state = S_MC_ACK;
      S_MC_ACK:    if (!mc_idle)    next_state = S_REL;
      S_REL:       if (!bus.ld_we)  next_state = S_LOAD_WAIT;
      S_DONE:      next_state = S_DONE;
      S_ERROR:     next_state = S_ERROR;
      default:     next_state = S_ERROR;
    endcase
  end

  always_ff @(posedge clk27mhz) begin
    if (!resetn) begin
      state        <= S_INIT;
      offset       <= 32'h0;
      wbuf         <= 32'h0;
      timer        <= 32'h0;
      mc_addr_q    <= 32'h0;
      mc_wdata_q   <= 32'h0;
      mc_we_q      <= 1'b0;
      ld_main_q    <= 3'd0;
      ld_ctrl_q    <= 8'h01;
      cpu_rst_n    <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      checksum     <= 32'h0;
      words_loaded <= 30'h0;
    end else begin
      state <= next_state;

      if (state == S_INIT && next_state == S_LOAD_WAIT) begin
        ld_main_q <= 3'd3;
        ld_ctrl_q <= 8'h00;
      end

      if (load_phase) timer <= timer_inc;

      // capture
      if (state == S_LOAD_WAIT && next_state == S_MC_REQ) begin
        wbuf      <= bus.ld_data;
        ld_ctrl_q <= 8'h01;
        timer     <= 32'h0;
      end

      // issue the write once the controller is idle
      if (state == S_MC_REQ && next_state == S_MC_ACK) begin
        mc_we_q    <= 1'b1;
        mc_addr_q  <= BASE_ADDR + offset;
        mc_wdata_q <= wbuf;
      end

      // controller accepted: drop the request and commit the word
      if (state == S_MC_ACK && next_state == S_REL) begin
        mc_we_q      <= 1'b0;
        offset       <= offset + 32'd4;
        checksum     <= checksum + wbuf;
        words_loaded <= words_loaded + 30'd1;
      end

      if (state == S_REL && next_state == S_LOAD_WAIT) ld_ctrl_q <= 8'h00;

      if (state != S_DONE && next_state == S_DONE) begin
        load_done <= 1'b1;
        cpu_rst_n <= 1'b1;
        ld_main_q <= 3'd0;
      end

      if (state != S_ERROR && next_state == S_ERROR) begin
        load_err  <= 1'b1;
        cpu_rst_n <= 1'b0;
        mc_we_q   <= 1'b0;
        ld_main_q <= 3'd0;
      end
    end
  end

  // Once booted the CPU owns the memory port through a combinational path;
  // before that it sees a permanently busy controller and zero read data.
  assign bus.mc_addr            = in_done ? bus.cpu_addr      : mc_addr_q;
  assign bus.mc_wdata           = in_done ? bus.cpu_wdata     : mc_wdata_q;
  assign bus.mc_we              = in_done ? bus.cpu_we        : mc_we_q;
  assign bus.mc_re              = in_done ? bus.cpu_re        : 1'b0;
  assign bus.cpu_rdata          = in_done ? bus.mc_rdata      : 32'h0;
  assign bus.cpu_ctrl_state     = in_done ? bus.mc_ctrl_state : 8'hFF;
  assign bus.ld_main_init_state = ld_main_q;
  assign bus.ld_ctrl_state      = ld_ctrl_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_boot_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sd_boot_sequencer
// Purpose  : Self-checking bench for sd_boot_sequencer. Directed loader
//            sequences push expected memory writes into a queue; a monitor
//            pops and compares every write the memory model accepts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_boot_sequencer;
  logic        clk27mhz = 1'b0;
  logic        resetn   = 1'b0;
  logic        cpu_rst_n;
  logic        load_done;
  logic        load_err;
  logic [31:0] checksum;
  logic [29:0] words_loaded;

  always #5 clk27mhz = ~clk27mhz;

  sd_boot_sequencer_if bus ();

  sd_boot_sequencer #(
    .BASE_ADDR(32'h0000_0000),
    .BIN_BYTES(32'd16),
    .TIMEOUT  (32'd100)
  ) dut (
    .clk27mhz    (clk27mhz),
    .resetn      (resetn),
    .bus         (bus),
    .cpu_rst_n   (cpu_rst_n),
    .load_done   (load_done),
    .load_err    (load_err),
    .checksum    (checksum),
    .words_loaded(words_loaded)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] exp_off = 32'h0;
  int          checks  = 0;
  int          errors  = 0;
  int          writes  = 0;
  bit          we_busy = 1'b0;

  // memory model controls
  int          ack_delay  = 2;
  int          busy_left  = 0;
  bit          mem_manual = 1'b0;
  logic [7:0]  manual_val = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk27mhz);
      #1;
    end
  endtask

  // Memory controller model: sole driver of mc_ctrl_state.
  initial begin
    int cnt;
    cnt = 0;
    bus.mc_ctrl_state = 8'h00;
    forever begin
      @(posedge clk27mhz);
      #1;
      if (mem_manual) begin
        bus.mc_ctrl_state = manual_val;
      end else if (busy_left > 0) begin
        bus.mc_ctrl_state = 8'h05;
        busy_left--;
      end else if (bus.mc_ctrl_state != 8'h00) begin
        bus.mc_ctrl_state = 8'h00;
      end else if (bus.mc_we && !load_done) begin
        cnt++;
        if (cnt >= ack_delay) begin
          bus.mc_ctrl_state = 8'h01;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: a write is accepted when mc_we meets a non-idle controller.
  always @(negedge clk27mhz) begin
    if (bus.mc_we && bus.mc_ctrl_state == 8'h05 && !load_done) we_busy = 1'b1;
    if (bus.mc_we && bus.mc_ctrl_state != 8'h00 && !load_done) begin
      writes++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%08h/%08h required=none", bus.mc_addr, bus.mc_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", bus.mc_addr, e.addr);
        chk("write_data", bus.mc_wdata, e.data);
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input bit expect_write, input bit expect_ack);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.ld_ctrl_state == 8'h00 && bus.ld_main_init_state == 3'd3) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
    if (!ok) begin
      chk("loader_ready_timeout", 32'd0, 32'd1);
      return;
    end
    if (expect_write) begin
      exp_q.push_back({exp_off, d});
      exp_off = exp_off + 32'd4;
    end
    bus.ld_data = d;
    bus.ld_we   = 1'b1;
    if (expect_ack) begin
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
        cyc(1);
        if (bus.ld_ctrl_state != 8'h00) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) chk("loader_ack_timeout", 32'd0, 32'd1);
    end else begin
      cyc(3);
    end
    bus.ld_we = 1'b0;
  endtask

  task automatic finish_load();
    bit ok;
    ok = 1'b0;
    bus.ld_done = 1'b1;
    for (int i = 0; i < 200; i++) begin
      cyc(1);
      if (load_done || load_err) begin
        ok = 1'b1;
        break;
      end
    end
    bus.ld_done = 1'b0;
    if (!ok) chk("status_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    bus.ld_we   = 1'b0;
    bus.ld_done = 1'b0;
    bus.cpu_we  = 1'b0;
    bus.cpu_re  = 1'b0;
    mem_manual  = 1'b0;
    busy_left   = 0;
    ack_delay   = 2;
    resetn      = 1'b0;
    cyc(2);
    resetn  = 1'b1;
    exp_off = 32'h0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int w0;
    bit ok;
    bus.mc_init_done = 1'b0;
    bus.mc_rdata     = 32'hA5A5_5A5A;
    bus.ld_data      = 32'h0;
    bus.ld_we        = 1'b0;
    bus.ld_done      = 1'b0;
    bus.cpu_addr     = 32'h0;
    bus.cpu_wdata    = 32'h0;
    bus.cpu_we       = 1'b0;
    bus.cpu_re       = 1'b0;
    resetn           = 1'b0;
    cyc(3);

    // reset state
    chk("rst_mc_we", {31'h0, bus.mc_we}, 32'd0);
    chk("rst_mc_re", {31'h0, bus.mc_re}, 32'd0);
    chk("rst_mc_addr", bus.mc_addr, 32'h0);
    chk("rst_mc_wdata", bus.mc_wdata, 32'h0);
    chk("rst_ld_main", {29'h0, bus.ld_main_init_state}, 32'd0);
    chk("rst_ld_ctrl", {24'h0, bus.ld_ctrl_state}, 32'h01);
    chk("rst_cpu_rst_n", {31'h0, cpu_rst_n}, 32'd0);
    chk("rst_flags", {30'h0, load_done, load_err}, 32'd0);
    chk("rst_checksum", checksum, 32'h0);
    chk("rst_words", {2'b0, words_loaded}, 32'd0);
    chk("rst_cpu_ctrl", {24'h0, bus.cpu_ctrl_state}, 32'hFF);
    chk("rst_cpu_rdata", bus.cpu_rdata, 32'h0);

    // stays in INIT until the controller is calibrated
    resetn = 1'b1;
    cyc(3);
    chk("init_hold_ld_main", {29'h0, bus.ld_main_init_state}, 32'd0);
    bus.mc_init_done = 1'b1;
    cyc(2);
    chk("load_wait_ld_main", {29'h0, bus.ld_main_init_state}, 32'd3);
    chk("load_wait_ld_ctrl", {24'h0, bus.ld_ctrl_state}, 32'h00);

    // nominal load
    send_word(32'd1, 1'b1, 1'b1);
    send_word(32'd2, 1'b1, 1'b1);
    send_word(32'd3, 1'b1, 1'b1);
    send_word(32'd4, 1'b1, 1'b1);
    finish_load();
    chk("nom_checksum", checksum, 32'd10);
    chk("nom_words", {2'b0, words_loaded}, 32'd4);
    chk("nom_load_done", {31'h0, load_done}, 32'd1);
    chk("nom_load_err", {31'h0, load_err}, 32'd0);
    chk("nom_cpu_rst_n", {31'h0, cpu_rst_n}, 32'd1);
    chk("nom_ld_main", {29'h0, bus.ld_main_init_state}, 32'd0);
    chk("nom_queue_drained", exp_q.size(), 32'd0);

    // CPU pass-through after boot
    mem_manual = 1'b1;
    manual_val = 8'h07;
    cyc(2);
    chk("cpu_ctrl_tracks", {24'h0, bus.cpu_ctrl_state}, 32'h07);
    bus.cpu_addr  = 32'h0000_0040;
    bus.cpu_wdata = 32'hDEAD_BEEF;
    bus.cpu_we    = 1'b1;
    bus.mc_rdata  = 32'h1234_5678;
    #1;
    chk("pt_mc_addr", bus.mc_addr, 32'h0000_0040);
    chk("pt_mc_wdata", bus.mc_wdata, 32'hDEAD_BEEF);
    chk("pt_mc_we", {31'h0, bus.mc_we}, 32'd1);
    chk("pt_mc_re_low", {31'h0, bus.mc_re}, 32'd0);
    chk("pt_cpu_rdata", bus.cpu_rdata, 32'h1234_5678);
    bus.cpu_we = 1'b0;
    bus.cpu_re = 1'b1;
    #1;
    chk("pt_mc_re", {31'h0, bus.mc_re}, 32'd1);
    chk("pt_mc_we_low", {31'h0, bus.mc_we}, 32'd0);
    bus.cpu_re = 1'b0;
    cyc(1);

    // controller busy during capture, then short image
    do_reset();
    busy_left = 20;
    cyc(2);
    w0      = writes;
    we_busy = 1'b0;
    send_word(32'h10, 1'b1, 1'b1);
    cyc(10);
    chk("busy_no_write", writes - w0, 32'd0);
    chk("busy_mc_we_low", {31'h0, bus.mc_we}, 32'd0);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cyc(1);
      if (writes - w0 >= 1) begin
        ok = 1'b1;
        break;
      end
    end
    cyc(5);
    chk("busy_one_write", writes - w0, 32'd1);
    chk("busy_we_while_busy", {31'h0, we_busy}, 32'd0);
    send_word(32'h20, 1'b1, 1'b1);
    send_word(32'h30, 1'b1, 1'b1);
    finish_load();
    chk("short_load_err", {31'h0, load_err}, 32'd1);
    chk("short_load_done", {31'h0, load_done}, 32'd0);
    chk("short_cpu_rst_n", {31'h0, cpu_rst_n}, 32'd0);
    chk("short_ld_main", {29'h0, bus.ld_main_init_state}, 32'd0);
    chk("short_checksum", checksum, 32'h60);
    chk("short_words", {2'b0, words_loaded}, 32'd3);
    chk("short_cpu_ctrl", {24'h0, bus.cpu_ctrl_state}, 32'hFF);
    chk("short_queue_drained", exp_q.size(), 32'd0);

    // overlong image: fifth word rejected, checksum wraps
    do_reset();
    send_word(32'hFFFF_FFFF, 1'b1, 1'b1);
    send_word(32'd2, 1'b1, 1'b1);
    send_word(32'd3, 1'b1, 1'b1);
    send_word(32'd4, 1'b1, 1'b1);
    send_word(32'd5, 1'b0, 1'b0);
    cyc(5);
    chk("ovf_load_err", {31'h0, load_err}, 32'd1);
    chk("ovf_load_done", {31'h0, load_done}, 32'd0);
    chk("ovf_words", {2'b0, words_loaded}, 32'd4);
    chk("ovf_checksum_wrap", checksum, 32'd8);
    chk("ovf_queue_drained", exp_q.size(), 32'd0);

    // loader stall: error exactly TIMEOUT cycles after the capture edge
    do_reset();
    w0 = writes;
    send_word(32'h77, 1'b1, 1'b1);
    cyc(99);
    chk("tmo_err_before", {31'h0, load_err}, 32'd0);
    cyc(1);
    chk("tmo_err_at", {31'h0, load_err}, 32'd1);
    chk("tmo_cpu_rst_n", {31'h0, cpu_rst_n}, 32'd0);
    cyc(10);
    chk("tmo_one_write", writes - w0, 32'd1);
    chk("tmo_mc_we", {31'h0, bus.mc_we}, 32'd0);

    // reset while a write is outstanding, then reload
    do_reset();
    send_word(32'h11, 1'b1, 1'b1);
    cyc(6);
    ack_delay = 50;
    send_word(32'h22, 1'b0, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.mc_we) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
    chk("mid_we_high", {31'h0, bus.mc_we}, 32'd1);
    resetn = 1'b0;
    cyc(1);
    chk("mid_we_dropped", {31'h0, bus.mc_we}, 32'd0);
    chk("mid_checksum", checksum, 32'h0);
    chk("mid_words", {2'b0, words_loaded}, 32'd0);
    chk("mid_ld_ctrl", {24'h0, bus.ld_ctrl_state}, 32'h01);
    chk("mid_ld_main", {29'h0, bus.ld_main_init_state}, 32'd0);
    resetn    = 1'b1;
    ack_delay = 2;
    exp_off   = 32'h0;
    send_word(32'd5, 1'b1, 1'b1);
    send_word(32'd6, 1'b1, 1'b1);
    send_word(32'd7, 1'b1, 1'b1);
    send_word(32'd8, 1'b1, 1'b1);
    finish_load();
    chk("reload_done", {31'h0, load_done}, 32'd1);
    chk("reload_err", {31'h0, load_err}, 32'd0);
    chk("reload_checksum", checksum, 32'd26);
    chk("reload_words", {2'b0, words_loaded}, 32'd4);
    chk("reload_cpu_rst_n", {31'h0, cpu_rst_n}, 32'd1);

    cyc(5);
    chk("final_queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
